// File: rtl/fma_pkg.sv
// Shared request/response types and the tile-count helper used by mul_pipe.
// MUL_PIPE_SIGNED_EN adds a per-request sign flag to mul_req_t.
package fma_pkg;

   localparam int MUL_AW   = 53;
   localparam int MUL_BW   = 53;
   localparam int MUL_TW   = 27;
   localparam int MUL_TAGW = 4;

   function automatic int ntiles(input int w, input int tw);
      return (w + tw - 1) / tw;
   endfunction

   typedef struct packed {
      logic [MUL_AW-1:0]   a;
      logic [MUL_BW-1:0]   b;
      logic [MUL_TAGW-1:0] tag;
`ifdef MUL_PIPE_SIGNED_EN
      logic                sgn;
`endif
   } mul_req_t;

   typedef struct packed {
      logic [MUL_AW+MUL_BW-1:0] p;
      logic [MUL_TAGW-1:0]      tag;
   } mul_rsp_t;

endpackage

// File: rtl/mul_tile.sv
// TW x TW unsigned multiplier with a registered 2*TW-bit product.
// Product register loads only when en is high and otherwise holds.
module mul_tile #(
   parameter int TW = 27
) (
   input  logic            clk,
   input  logic            en,
   input  logic [TW-1:0]   a,
   input  logic [TW-1:0]   b,
   output logic [2*TW-1:0] p
);

   always_ff @(posedge clk) begin
      if (en) begin
         p <= {{TW{1'b0}}, a} * {{TW{1'b0}}, b};
      end
   end

endmodule

// File: rtl/mul_pipe.sv
// Three-stage AxB multiplier (operands, tile products, tile sum) with valid/ready per stage.
// Accepted beat is on out_p two edges later; MUL_PIPE_SIGNED_EN adds in_sgn for two's complement.
module mul_pipe
   import fma_pkg::*;
#(
   parameter int AW   = 53,
   parameter int BW   = 53,
   parameter int TW   = 27,
   parameter int TAGW = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [AW-1:0]     in_a,
   input  logic [BW-1:0]     in_b,
   input  logic [TAGW-1:0]   in_tag,
`ifdef MUL_PIPE_SIGNED_EN
   input  logic              in_sgn,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [AW+BW-1:0]  out_p,
   output logic [TAGW-1:0]   out_tag,
   output logic              busy
);

   localparam int NA = ntiles(AW, TW);
   localparam int NB = ntiles(BW, TW);
   localparam int PW = AW + BW;
   localparam int AP = NA * TW;
   localparam int BP = NB * TW;

   typedef struct packed {
      logic [AW-1:0]   a;
      logic [BW-1:0]   b;
      logic [TAGW-1:0] tag;
`ifdef MUL_PIPE_SIGNED_EN
      logic            sgn;
`endif
   } req_t;

   typedef struct packed {
      logic [PW-1:0]   p;
      logic [TAGW-1:0] tag;
   } rsp_t;

   logic v0, v1, v2;
   logic adv0, adv1;
   logic ld0, ld1, ld2;

   req_t            s0;
   logic [TAGW-1:0] tag1;
   rsp_t            s2;

   logic [AP-1:0]     a_pad;
   logic [BP-1:0]     b_pad;
   logic [2*TW-1:0]   tile_p [NA*NB];
   logic [PW-1:0]     sum;

`ifdef MUL_PIPE_SIGNED_EN
   logic [AW-1:0] a1;
   logic [BW-1:0] b1;
   logic          sgn1;
`endif

   // A stage may move forward when the next one is empty or is itself moving.
   assign adv1     = !v2 || out_ready;
   assign adv0     = !v1 || adv1;
   assign in_ready = (!v0 || adv0) && !flush;

   assign ld0 = in_valid && in_ready;
   assign ld1 = v0 && adv0 && !flush;
   assign ld2 = v1 && adv1 && !flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v0 <= 1'b0;
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else if (flush) begin
         v0 <= 1'b0;
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         if (!v0 || adv0) v0 <= in_valid;
         if (adv0)        v1 <= v0;
         if (adv1)        v2 <= v1;
      end
   end

   always_ff @(posedge clk) begin
      if (ld0) begin
         s0.a   <= in_a;
         s0.b   <= in_b;
         s0.tag <= in_tag;
`ifdef MUL_PIPE_SIGNED_EN
         s0.sgn <= in_sgn;
`endif
      end
   end

   assign a_pad = AP'(s0.a);
   assign b_pad = BP'(s0.b);

   for (genvar gi = 0; gi < NA; gi++) begin : g_row
      for (genvar gj = 0; gj < NB; gj++) begin : g_col
         mul_tile #(.TW(TW)) u_tile (
            .clk (clk),
            .en  (ld1),
            .a   (a_pad[gi*TW +: TW]),
            .b   (b_pad[gj*TW +: TW]),
            .p   (tile_p[gi*NB+gj])
         );
      end
   end

   always_ff @(posedge clk) begin
      if (ld1) begin
         tag1 <= s0.tag;
`ifdef MUL_PIPE_SIGNED_EN
         a1   <= s0.a;
         b1   <= s0.b;
         sgn1 <= s0.sgn;
`endif
      end
   end

   // Tiles are always unsigned; for signed requests the weight of each operand's
   // sign bit is removed here (the cross term vanishes modulo 2^PW).
   always_comb begin
      sum = '0;
      for (int i = 0; i < NA; i++) begin
         for (int j = 0; j < NB; j++) begin
            sum = sum + (PW'(tile_p[i*NB+j]) << ((i + j) * TW));
         end
      end
`ifdef MUL_PIPE_SIGNED_EN
      if (sgn1) begin
         if (a1[AW-1]) sum = sum - (PW'(b1) << AW);
         if (b1[BW-1]) sum = sum - (PW'(a1) << BW);
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2 <= '0;
      end else if (ld2) begin
         s2.p   <= sum;
         s2.tag <= tag1;
      end
   end

   assign out_valid = v2;
   assign out_p     = s2.p;
   assign out_tag   = s2.tag;
   assign busy      = v0 || v1 || v2;

endmodule

// File: tb/tb_mul_pipe.sv
// Randomised and directed bench for mul_pipe against a queue-based product model.
// Build with MUL_PIPE_SIGNED_EN to exercise the signed port as well.
module tb_mul_pipe;
   import fma_pkg::*;

   localparam int AW   = MUL_AW;
   localparam int BW   = MUL_BW;
   localparam int TAGW = MUL_TAGW;
   localparam int PW   = AW + BW;
   localparam int NRAND = 300;

   logic            clk = 1'b0;
   logic            reset;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [AW-1:0]   in_a;
   logic [BW-1:0]   in_b;
   logic [TAGW-1:0] in_tag;
`ifdef MUL_PIPE_SIGNED_EN
   logic            in_sgn;
`endif
   logic            out_valid;
   logic            out_ready;
   logic [PW-1:0]   out_p;
   logic [TAGW-1:0] out_tag;
   logic            busy;

   int n_tests = 0;
   int n_fail  = 0;

   mul_rsp_t        model_q[$];
   logic [TAGW-1:0] seen_q[$];

   mul_pipe #(.AW(AW), .BW(BW), .TW(MUL_TW), .TAGW(TAGW)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
`ifdef MUL_PIPE_SIGNED_EN
      .in_sgn    (in_sgn),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] ref_prod(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                              input logic sgn);
      logic [PW-1:0] ea, eb;
      ea = sgn ? {{BW{a[AW-1]}}, a} : {{BW{1'b0}}, a};
      eb = sgn ? {{AW{b[BW-1]}}, b} : {{AW{1'b0}}, b};
      return ea * eb;
   endfunction

   // Scoreboard: every accepted beat queues its product; every beat on the
   // output must match the oldest outstanding one, stalled or not.
   always @(negedge clk) begin
      if (reset) begin
         logic cur_sgn;
`ifdef MUL_PIPE_SIGNED_EN
         cur_sgn = in_sgn;
`else
         cur_sgn = 1'b0;
`endif
         if (out_valid) begin
            if (model_q.size() == 0) begin
               chk("spurious_out_valid", 1, 0);
            end else begin
               chk("sb_out_p", out_p, model_q[0].p);
               chk("sb_out_tag", out_tag, model_q[0].tag);
               if (out_ready) begin
                  seen_q.push_back(out_tag);
                  void'(model_q.pop_front());
               end
            end
         end
         if (flush) model_q.delete();
         else if (in_valid && in_ready)
            model_q.push_back('{p: ref_prod(in_a, in_b, cur_sgn), tag: in_tag});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [TAGW-1:0] tag);
      logic r;
      in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
      for (int k = 0; k < 64; k++) begin
         #1;
         r = in_ready;
         @(posedge clk);
         #1;
         if (r) begin
            in_valid = 1'b0;
            return;
         end
      end
      chk("send_timeout", 1, 0);
      in_valid = 1'b0;
   endtask

   task automatic get(output logic [PW-1:0] p, output logic [TAGW-1:0] tag);
      p = '0; tag = '0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (out_valid) begin
            p = out_p; tag = out_tag;
            step();
            return;
         end
      end
      chk("get_timeout", 1, 0);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int k = 0; k < 200; k++) begin
         if (!busy && model_q.size() == 0) break;
         step();
      end
      chk("drain_idle", busy, 0);
      chk("drain_model_empty", model_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [PW-1:0]   p;
      logic [TAGW-1:0] t;
      logic [63:0]     ra, rb;
      logic [PW-1:0]   e;
      logic            r;
      int              sent, cyc;

      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_tag = '0;
`ifdef MUL_PIPE_SIGNED_EN
      in_sgn = 1'b0;
`endif
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_p", out_p, 0);
      chk("rst_out_tag", out_tag, 0);
      @(negedge clk);
      reset = 1'b1;

      // Single beat: accepted at edge 0, visible after edge 2, consumed at edge 3.
      out_ready = 1'b1;
      step();
      in_a = 3; in_b = 5; in_tag = 1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("lat_e0_valid", out_valid, 0);
      step();
      chk("lat_e1_valid", out_valid, 0);
      step();
      chk("lat_e2_valid", out_valid, 1);
      chk("lat_p", out_p, 15);
      chk("lat_tag", out_tag, 1);
      step();
      chk("lat_e3_valid", out_valid, 0);

      // Carries across tile boundaries.
      send((AW'(1) << 52) | AW'(1), (BW'(1) << 52) | BW'(1), 2);
      get(p, t);
      e = (PW'(1) << 104) + (PW'(1) << 53) + PW'(1);
      chk("carry1_p", p, e);
      send('1, '1, 3);
      get(p, t);
      e = (PW'(1) << 106) - (PW'(1) << 54) + PW'(1);
      chk("carry2_p", p, e);
      chk("carry2_tag", t, 3);

      // Back-pressure: three beats fill the pipe, the fourth waits.
      seen_q.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(AW'($urandom), BW'($urandom), TAGW'(i));
      in_a = AW'(77); in_b = BW'(99); in_tag = 3; in_valid = 1'b1;
      #1;
      chk("bp_in_ready_full", in_ready, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_tag", out_tag, 0);
         chk("bp_hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      send(AW'(77), BW'(99), 3);
      send(AW'(1234567), BW'(7654321), 4);
      drain();
      chk("bp_count", seen_q.size(), 5);
      for (int i = 0; i < 5 && i < seen_q.size(); i++) chk("bp_order", seen_q[i], i);

      // Flush with three beats in flight and a fourth offered.
      seen_q.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(AW'($urandom), BW'($urandom), TAGW'(8 + i));
      in_a = AW'(5); in_b = BW'(6); in_tag = 11; in_valid = 1'b1; flush = 1'b1;
      #1;
      chk("flush_in_ready", in_ready, 0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_busy", busy, 0);
      chk("flush_out_valid", out_valid, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("flush_no_output", seen_q.size(), 0);
      chk("flush_still_idle", out_valid, 0);

      // Asynchronous reset in the middle of a stream.
      out_ready = 1'b1;
      in_a = AW'(1000); in_b = BW'(2000); in_tag = 5; in_valid = 1'b1;
      step();
      step();
      reset = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_out_p", out_p, 0);
      model_q.delete();
      step();
      reset = 1'b1;
      step();
      send(AW'(12345), BW'(678), 9);
      get(p, t);
      chk("post_rst_p", p, 12345 * 678);
      chk("post_rst_tag", t, 9);

`ifdef MUL_PIPE_SIGNED_EN
      in_sgn = 1'b1;
      send('1, BW'(3), 6);
      in_sgn = 1'b0;
      get(p, t);
      e = '1;
      e = e - PW'(2);
      chk("sgn_neg3", p, e);
      send('1, BW'(3), 7);
      get(p, t);
      e = PW'(3) * ((PW'(1) << 53) - PW'(1));
      chk("sgn_off", p, e);
`endif

      // Random traffic with random consumer stalls.
      sent = 0; cyc = 0;
      while (sent < NRAND && cyc < 20000) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
               0: ra = '1;
               1: rb = '1;
               2: ra = 64'd0;
               default: ;
            endcase
            in_a = ra[AW-1:0]; in_b = rb[BW-1:0]; in_tag = TAGW'($urandom);
`ifdef MUL_PIPE_SIGNED_EN
            in_sgn = $urandom_range(0, 1) == 1;
`endif
            in_valid = 1'b1;
         end
         #1;
         r = in_ready;
         step();
         if (in_valid && r) begin
            in_valid = 1'b0;
            sent++;
         end
         cyc++;
      end
      chk("rand_all_sent", sent, NRAND);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
